// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - signal bundle between period_meter and its user
//
// Purpose: groups the divided-clock input, the enable and the measurement
// results of period_meter into one interface.
// Signals:
//   div_in       - divided clock, asynchronous to the system clock
//   enable       - synchronous measurement enable
//   period       - last completed period, in system clock cycles
//   period_valid - one-cycle pulse marking a new period value
//   timeout      - sticky: no rising edge within 2^CNT_W-1 cycles
//   busy         - high while a measurement is running
// Modports: master drives div_in/enable, slave (the meter) drives the rest.
interface period_meter_if #(
  parameter int CNT_W = 24
);
  logic             div_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output div_in,
    output enable,
    input  period,
    input  period_valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  div_in,
    input  enable,
    output period,
    output period_valid,
    output timeout,
    output busy
  );
endinterface

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the period of a divided clock in clk cycles
//
// Purpose: synchronises div_in, detects its rising edges and counts clk
// cycles between consecutive edges. The first edge after arming only starts
// the count; every later edge publishes the count and restarts it.
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   reset - asynchronous active-high reset
//   pm    - period_meter_if.slave: div_in/enable in, period, period_valid,
//           timeout and busy out (all registered)
module period_meter #(
  parameter int CNT_W = 24
) (
  input  logic           clk,
  input  logic           reset,
  period_meter_if.slave  pm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             rise;

  // The synchroniser chain runs independently of enable, so s3 always
  // tracks s2 and re-enabling cannot manufacture a stale edge.
  always_comb begin
    s1_d = pm.div_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!pm.enable) begin
      // Disable wins over any edge or timeout in the same cycle.
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = CNT_ZERO;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // An edge at the terminal count is still a valid measurement.
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = CNT_ZERO;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    busy_d = (state_d == MEASURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
    end
  end

  assign pm.period       = period_q;
  assign pm.period_valid = valid_q;
  assign pm.timeout      = timeout_q;
  assign pm.busy         = busy_q;

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, the width of the period counter and result (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port div_in, input, 1, the divided clock from the frequency divider, asynchronous to clk.
REQ-005 SHALL have port enable, input, 1, synchronous measurement enable.
REQ-006 SHALL have port period, output, CNT_W, the last completed period measurement in clk cycles.
REQ-007 SHALL have port period_valid, output, 1, a one-cycle pulse marking a new period value.
REQ-008 SHALL have port timeout, output, 1, a sticky flag meaning no rising edge was seen within 2^CNT_W-1 cycles.
REQ-009 SHALL have port busy, output, 1, high while in state MEASURE.

Function
REQ-010 SHALL synchronise div_in through two flops (s1, s2), then register s2 into s3.
REQ-011 SHALL define rise = s2 AND NOT s3; only rise is used downstream.
REQ-012 SHALL reach a registered output on the 3rd rising clk edge that samples div_in high; the first sampling edge counts as 1.
REQ-013 SHALL detect a div_in rising edge only when div_in is high for at least 1 clk period and low for at least 1 clk period; behaviour for narrower pulses is unspecified.
REQ-014 SHALL implement FSM states IDLE, ARM and MEASURE, all registered.
REQ-015 SHALL move from IDLE to ARM when enable=1; cnt is held at 0 in IDLE.
REQ-016 SHALL move from ARM to MEASURE on rise and set cnt to 1; period_valid is not asserted on this first edge.
REQ-017 SHALL, in MEASURE with no rise, set cnt to cnt+1.
REQ-018 SHALL, in MEASURE on rise:
- set period to cnt;
- pulse period_valid for 1 cycle;
- clear timeout;
- set cnt to 1 and stay in MEASURE.
REQ-019 SHALL give a div_in period of N clk cycles a reported period of N.
REQ-020 SHALL, in MEASURE with cnt = 2^CNT_W-1 and no rise:
- set timeout to 1;
- hold period;
- keep period_valid at 0;
- set cnt to 0 and go to ARM.
REQ-021 SHALL, in MEASURE with cnt = 2^CNT_W-1 and rise in the same cycle, treat it as a normal measurement with period = 2^CNT_W-1; timeout is not set.
REQ-022 SHALL, when enable=0 in any state:
- go to IDLE next cycle;
- set cnt to 0;
- keep period_valid at 0;
- hold period and timeout.
REQ-023 SHALL give enable=0 priority over rise and over the timeout condition in the same cycle.
REQ-024 SHALL never wrap cnt past 2^CNT_W-1.
REQ-025 SHALL have period change only in the same cycle that period_valid=1.
REQ-026 SHALL keep s1, s2 and s3 running whenever reset=0, regardless of enable, so no false rise occurs on re-enable.

Reset
REQ-027 SHALL, while reset=1 (asynchronous), force:
- state=IDLE;
- cnt=0, s1=s2=s3=0;
- period=0, period_valid=0, timeout=0, busy=0.
REQ-028 SHALL discard any partial measurement on reset in mid-operation; the first period_valid after release requires two detected rises.
REQ-029 SHALL need no clk edge to take effect when reset asserts; release may be asynchronous to clk, and the design is not required to detect a rise in the first cycle after release.

Verification
REQ-030 SHALL cover: CNT_W=24, enable=1, div_in period 10 clk (5 high/5 low) -> no valid on 1st edge, then period_valid every 10 cycles with period=10, busy=1, timeout=0.
REQ-031 SHALL cover: div_in period 2 clk (1 high/1 low) -> period=2 on every pulse; switch to period 7 (3/4) -> next period=7.
REQ-032 SHALL cover: CNT_W=4, one div_in edge then div_in held low -> timeout=1 exactly 15 cycles after MEASURE entry, state ARM, busy=0, period unchanged; next two edges 6 apart -> period=6, timeout=0.
REQ-033 SHALL cover: enable dropped mid-MEASURE for 3 cycles and coincident with a rise -> no period_valid, period held; after re-enable the first edge only arms.
REQ-034 SHALL cover: reset pulsed high mid-MEASURE between clk edges -> all outputs 0 immediately; after release, periods of 10 clk -> first valid period=10 at the second post-reset edge.
